// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: trains the predictor, flushes on mispredict and ignores the wrong-path shadow.
// Optional performance counters are enabled with the BRU_PERF_CNT_EN macro.
module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned XLEN         = 32
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_cond_taken,
  input  logic [XLEN-1:0] ex_actual_target,
  input  logic            ex_prd_taken,
  input  logic [XLEN-1:0] ex_prd_target,
  output logic            br_update,
  output logic            br_update_taken,
  output logic [XLEN-1:0] br_update_target,
  output logic [XLEN-1:0] br_update_PC,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_br_cnt,
  output logic [31:0]     perf_mispred_cnt
`endif
);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            br_update_q, br_update_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic            busy_q, busy_d;

  logic            res;
  logic            act_taken;
  logic            mispredict;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] act_target;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_mis_q, perf_mis_d;
`endif

  always_comb begin
    // A jump dominates when both type bits are set.
    act_taken  = ex_is_jump | (ex_is_branch & ex_cond_taken);
    seq_pc     = ex_pc + XLEN'(4);
    act_target = act_taken ? ex_actual_target : seq_pc;
    mispredict = (act_taken != ex_prd_taken) |
                 (act_taken & ex_prd_taken & (ex_actual_target != ex_prd_target));
    res        = ex_valid & ~ex_stall & (ex_is_branch | ex_is_jump) & (state_q == RUN);

    state_d     = state_q;
    cnt_d       = cnt_q;
    br_update_d = res;
    flush_d     = res & mispredict;
    taken_d     = taken_q;
    target_d    = target_q;
    pc_d        = pc_q;
    redirect_d  = redirect_q;

    if (res) begin
      taken_d  = act_taken;
      target_d = act_target;
      pc_d     = ex_pc;
    end
    if (res & mispredict) begin
      redirect_d = act_target;
    end

    case (state_q)
      RUN: begin
        if (res & mispredict) begin
          state_d = FLUSH;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        // Counts down independently of ex_stall; leaves when the count has reached zero.
        if (cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == FLUSH);

`ifdef BRU_PERF_CNT_EN
    perf_br_d  = perf_br_q + {31'd0, br_update_d};
    perf_mis_d = perf_mis_q + {31'd0, flush_d};
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      br_update_q <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= '0;
      pc_q        <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      busy_q      <= 1'b0;
`ifdef BRU_PERF_CNT_EN
      perf_br_q   <= '0;
      perf_mis_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      br_update_q <= br_update_d;
      taken_q     <= taken_d;
      target_q    <= target_d;
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      busy_q      <= busy_d;
`ifdef BRU_PERF_CNT_EN
      perf_br_q   <= perf_br_d;
      perf_mis_q  <= perf_mis_d;
`endif
    end
  end

  assign br_update        = br_update_q;
  assign br_update_taken  = taken_q;
  assign br_update_target = target_q;
  assign br_update_PC     = pc_q;
  assign flush            = flush_q;
  assign redirect_pc      = redirect_q;
  assign busy             = busy_q;
`ifdef BRU_PERF_CNT_EN
  assign perf_br_cnt      = perf_br_q;
  assign perf_mispred_cnt = perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expectations queued at drive time, compared after the edge.
module tb_branch_resolve_unit;

  localparam int unsigned FC = 2;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_stall = 1'b0, ex_is_branch = 1'b0, ex_is_jump = 1'b0;
  logic [31:0] ex_pc = '0, ex_actual_target = '0, ex_prd_target = '0;
  logic        ex_cond_taken = 1'b0, ex_prd_taken = 1'b0;
  logic        br_update, br_update_taken, flush, busy;
  logic [31:0] br_update_target, br_update_PC, redirect_pc;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_cnt, perf_mispred_cnt;
`endif

  branch_resolve_unit #(.FLUSH_CYCLES(FC), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_pc(ex_pc), .ex_cond_taken(ex_cond_taken),
    .ex_actual_target(ex_actual_target),
    .ex_prd_taken(ex_prd_taken), .ex_prd_target(ex_prd_target),
    .br_update(br_update), .br_update_taken(br_update_taken),
    .br_update_target(br_update_target), .br_update_PC(br_update_PC),
    .flush(flush), .redirect_pc(redirect_pc), .busy(busy)
`ifdef BRU_PERF_CNT_EN
    , .perf_br_cnt(perf_br_cnt), .perf_mispred_cnt(perf_mispred_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        upd;
    logic        fl;
    logic        bsy;
    logic        taken;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] redir;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          shadow   = 0;
  int unsigned m_br     = 0;
  int unsigned m_mis    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drive one instruction, queue the reference result, then compare after the edge.
  task automatic drive(input logic v, input logic st, input logic br, input logic jp,
                       input logic [31:0] pc, input logic cond, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptg, input string tag);
    exp_t e;
    logic tk, mis, r;
    logic [31:0] dst;
    ex_valid = v; ex_stall = st; ex_is_branch = br; ex_is_jump = jp; ex_pc = pc;
    ex_cond_taken = cond; ex_actual_target = tgt; ex_prd_taken = pt; ex_prd_target = ptg;
    tk  = jp | (br & cond);
    dst = tk ? tgt : pc + 32'd4;
    mis = (tk != pt) || (tk && pt && tgt != ptg);
    r   = v && !st && (br || jp) && shadow == 0;
    if (shadow > 0) shadow--;
    if (r && mis) shadow = FC;
    e.upd = r; e.fl = r && mis; e.bsy = shadow > 0;
    e.taken = tk; e.target = dst; e.pc = pc; e.redir = dst;
    if (e.upd) m_br++;
    if (e.fl) m_mis++;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_upd"}, {31'd0, br_update}, {31'd0, e.upd});
      check({tag, "_flush"}, {31'd0, flush}, {31'd0, e.fl});
      check({tag, "_busy"}, {31'd0, busy}, {31'd0, e.bsy});
      if (e.upd) begin
        check({tag, "_taken"}, {31'd0, br_update_taken}, {31'd0, e.taken});
        check({tag, "_target"}, br_update_target, e.target);
        check({tag, "_pc"}, br_update_PC, e.pc);
      end
      if (e.fl) check({tag, "_redir"}, redirect_pc, e.redir);
    end
  endtask

  task automatic idle(input string tag);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_upd"}, {31'd0, br_update}, 32'd0);
    check({tag, "_flush"}, {31'd0, flush}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_taken"}, {31'd0, br_update_taken}, 32'd0);
    check({tag, "_target"}, br_update_target, 32'd0);
    check({tag, "_pc"}, br_update_PC, 32'd0);
    check({tag, "_redir"}, redirect_pc, 32'd0);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk_i); #1;

    // Correct taken branch, then a non-branch valid instruction.
    drive(1, 0, 1, 0, 32'h100, 1, 32'h140, 1, 32'h140, "ok_taken");
    drive(1, 0, 0, 0, 32'h104, 0, 32'h0, 0, 32'h0, "nonbr");
    // Direction mispredict followed by two shadowed branches and one resolved.
    drive(1, 0, 1, 0, 32'h200, 0, 32'h280, 1, 32'h280, "dir_mis");
    drive(1, 0, 1, 0, 32'h210, 1, 32'h260, 1, 32'h260, "shadow1");
    drive(1, 0, 1, 0, 32'h214, 1, 32'h260, 1, 32'h260, "shadow2");
    drive(1, 0, 1, 0, 32'h218, 1, 32'h260, 1, 32'h260, "after_sh");
    // JALR target mispredict; shadow counts down even while stalled.
    drive(1, 0, 0, 1, 32'h300, 0, 32'h480, 1, 32'h400, "tgt_mis");
    drive(1, 1, 1, 0, 32'h484, 1, 32'h500, 1, 32'h500, "sh_stall");
    idle("sh_idle");
    drive(1, 1, 1, 0, 32'h490, 1, 32'h500, 0, 32'h500, "stall");
    // Back-to-back correct branches, including a correct not-taken.
    drive(1, 0, 1, 0, 32'h600, 1, 32'h700, 1, 32'h700, "b2b_a");
    drive(1, 0, 1, 0, 32'h700, 0, 32'h800, 0, 32'h0, "b2b_nt");
    // PC+4 wraps to zero.
    drive(1, 0, 1, 0, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10, "wrap");
    idle("wrap_i1");
    idle("wrap_i2");
    // Branch and jump both set behaves as a jump.
    drive(1, 0, 1, 1, 32'h900, 0, 32'hA00, 0, 32'h0, "both");
    idle("both_i1");
    idle("both_i2");
    drive(1, 0, 0, 1, 32'hB00, 0, 32'hC00, 1, 32'hC00, "jal_ok");
`ifdef BRU_PERF_CNT_EN
    check("perf_br", perf_br_cnt, m_br);
    check("perf_mis", perf_mispred_cnt, m_mis);
`endif
    // Asynchronous reset in the middle of FLUSH.
    drive(1, 0, 1, 0, 32'hD00, 1, 32'hE00, 0, 32'h0, "pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
`ifdef BRU_PERF_CNT_EN
    check("rst_perf_br", perf_br_cnt, 32'd0);
    check("rst_perf_mis", perf_mispred_cnt, 32'd0);
`endif
    @(posedge clk_i); #1;
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    shadow = 0;
    drive(1, 0, 1, 0, 32'hF00, 1, 32'hF40, 1, 32'hF40, "post_rst");
    idle("end_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
